// File: rtl/time_set_pkg.sv
// Shared types and constants for the time-set pulse generator.
// Optional feature macro used by this slice: AUTO_REPEAT_EN.
package time_set_pkg;

  localparam int SYNC_DEPTH = 2;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    HELD        = 3'd2,
    REPEAT      = 3'd3,
    DEB_RELEASE = 3'd4
  } btn_state_e;

  // Largest of three timing values; sizes the shared debounce/repeat counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_pulse.sv
// Synchronised, debounced push-button to one-cycle pulse converter.
// With AUTO_REPEAT_EN defined, a held button also emits repeat pulses.
module button_pulse
  import time_set_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
`endif

  logic [SYNC_DEPTH-1:0] sync_r;
  logic                  btn_s;
  btn_state_e            state_r, state_nxt_s;
  logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
  logic                  pulse_r, pulse_nxt_s;

  assign btn_s = sync_r[SYNC_DEPTH-1];
  assign pulse = pulse_r;

  // Synchroniser, FSM state, shared counter and pulse register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r  <= {SYNC_DEPTH{1'b0}};
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      pulse_r <= 1'b0;
    end else begin
      sync_r  <= {sync_r[SYNC_DEPTH-2:0], btn};
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      pulse_r <= pulse_nxt_s;
    end
  end

  // Next-state, counter and pulse decode; the counter is reused for every timed state.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    pulse_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_nxt_s = {CNT_W{1'b0}};
        if (btn_s) begin
          state_nxt_s = DEB_PRESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DEB_PRESS: begin
        if (!btn_s) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == DEB_LAST) begin
          state_nxt_s = HELD;
          cnt_nxt_s   = {CNT_W{1'b0}};
          pulse_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt_s = DEB_RELEASE;
          cnt_nxt_s   = {CNT_W{1'b0}};
`ifdef AUTO_REPEAT_EN
        end else if (cnt_r == RD_LAST) begin
          state_nxt_s = REPEAT;
          cnt_nxt_s   = {CNT_W{1'b0}};
          pulse_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
`else
        end else begin
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
`endif
      end
`ifdef AUTO_REPEAT_EN
      REPEAT: begin
        if (!btn_s) begin
          state_nxt_s = DEB_RELEASE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == RP_LAST) begin
          cnt_nxt_s   = {CNT_W{1'b0}};
          pulse_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
`endif
      DEB_RELEASE: begin
        // A bounce back high returns to HELD silently, so no new press pulse.
        if (btn_s) begin
          state_nxt_s = HELD;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == DEB_LAST) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/time_set_pulse_gen.sv
// Seconds prescaler plus hour/minute set-button pulse generators.
// Auto-repeat of held buttons is enabled by defining AUTO_REPEAT_EN.
module time_set_pulse_gen
  import time_set_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic sec_en,
  input  logic btn_hour,
  input  logic btn_min,
  output logic SECS,
  output logic MINS,
  output logic HOURS
);

  localparam int PS_W = $clog2(CLK_HZ);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_HZ - 1);

  logic [PS_W-1:0] ps_cnt_r;
  logic            secs_r;

  assign SECS = secs_r;

  // Prescaler: freezes with sec_en low and resumes from the held count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_cnt_r <= {PS_W{1'b0}};
      secs_r   <= 1'b0;
    end else if (sec_en) begin
      secs_r   <= (ps_cnt_r == PS_LAST);
      ps_cnt_r <= (ps_cnt_r == PS_LAST) ? {PS_W{1'b0}} : ps_cnt_r + PS_W'(1);
    end else begin
      secs_r   <= 1'b0;
    end
  end

  button_pulse #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_hour (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_hour),
    .pulse (HOURS)
  );

  button_pulse #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_min (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_min),
    .pulse (MINS)
  );

endmodule

// File: tb/tb_time_set_pulse_gen.sv
// Directed scoreboard bench for time_set_pulse_gen (small timing parameters).
// Expected repeat pulses follow AUTO_REPEAT_EN as defined for the build.
module tb_time_set_pulse_gen;

  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;
  localparam int RDLY   = 20;
  localparam int RPER   = 8;
  localparam int LAT    = 2 + DEB;

  logic clk = 1'b0;
  logic reset;
  logic sec_en;
  logic btn_hour;
  logic btn_min;
  logic SECS, MINS, HOURS;

  int cyc      = 0;
  int n_assert = 0;
  int n_fail   = 0;
  int q_secs[$];
  int q_mins[$];
  int q_hours[$];

  time_set_pulse_gen #(
    .CLK_HZ          (CLK_HZ),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RDLY),
    .REPEAT_PERIOD   (RPER)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sec_en   (sec_en),
    .btn_hour (btn_hour),
    .btn_min  (btn_min),
    .SECS     (SECS),
    .MINS     (MINS),
    .HOURS    (HOURS)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // A pulse must land on the cycle at the head of its queue; -1 means none expected.
  task automatic check_outputs();
    int e;
    if (SECS === 1'b1) begin
      e = (q_secs.size() != 0) ? q_secs.pop_front() : -1;
      chk("secs_pulse_cycle", cyc, e);
    end
    if (MINS === 1'b1) begin
      e = (q_mins.size() != 0) ? q_mins.pop_front() : -1;
      chk("mins_pulse_cycle", cyc, e);
    end
    if (HOURS === 1'b1) begin
      e = (q_hours.size() != 0) ? q_hours.pop_front() : -1;
      chk("hours_pulse_cycle", cyc, e);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      check_outputs();
    end
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_secs_left"},  q_secs.size(),  0);
    chk({tag, "_mins_left"},  q_mins.size(),  0);
    chk({tag, "_hours_left"}, q_hours.size(), 0);
  endtask

  initial begin
    int base;
    reset    = 1'b1;
    sec_en   = 1'b0;
    btn_hour = 1'b0;
    btn_min  = 1'b0;

    // Reset state
    tick(3);
    chk("rst_secs",  SECS,  0);
    chk("rst_mins",  MINS,  0);
    chk("rst_hours", HOURS, 0);

    // Free-running seconds: first edge after release is cycle 1
    reset  = 1'b0;
    sec_en = 1'b1;
    base   = cyc;
    q_secs.push_back(base + 10);
    q_secs.push_back(base + 20);
    q_secs.push_back(base + 30);
    tick(30);
    chk_drained("secs_run");

    // Pause at count 7 for 5 cycles: pulse moves from base+40 to base+45
    tick(7);
    sec_en = 1'b0;
    q_secs.push_back(base + 45);
    tick(5);
    sec_en = 1'b1;
    tick(4);
    sec_en = 1'b0;
    chk_drained("secs_pause");

    // Minute glitch of 3 cycles: no pulse
    btn_min = 1'b1;
    tick(3);
    btn_min = 1'b0;
    tick(12);
    chk_drained("min_glitch");

    // Minute press held 10 cycles: one pulse at +6
    q_mins.push_back(cyc + 1 + LAT);
    btn_min = 1'b1;
    tick(10);
    btn_min = 1'b0;
    tick(12);
    chk_drained("min_press");

    // Hour held 60 cycles
    base = cyc + 1;
    q_hours.push_back(base + LAT);
`ifdef AUTO_REPEAT_EN
    q_hours.push_back(base + 26);
    q_hours.push_back(base + 34);
    q_hours.push_back(base + 42);
    q_hours.push_back(base + 50);
    q_hours.push_back(base + 58);
`endif
    btn_hour = 1'b1;
    tick(60);
    btn_hour = 1'b0;
    tick(12);
    chk_drained("hour_hold");

    // Both buttons on the same edge
    q_hours.push_back(cyc + 1 + LAT);
    q_mins.push_back(cyc + 1 + LAT);
    btn_hour = 1'b1;
    btn_min  = 1'b1;
    tick(8);
    btn_hour = 1'b0;
    btn_min  = 1'b0;
    tick(12);
    chk_drained("both");

    // Reset while hour is HELD, released with button still high
    q_hours.push_back(cyc + 1 + LAT);
    btn_hour = 1'b1;
    tick(8);
    chk_drained("pre_reset");
    reset = 1'b1;
    tick(4);
    chk("mid_rst_hours", HOURS, 0);
    reset = 1'b0;
    q_hours.push_back(cyc + 1 + LAT);
    tick(10);
    btn_hour = 1'b0;
    tick(12);
    chk_drained("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
